mdr_sequencer: RTL and testbench

//  Sequences the multiply/divide/square-root (MDR) datapath. Accepts one op request, registers the

---
 rtl/mdr_sequencer_if.sv | 36 +++
 rtl/mdr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mdr_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdr_sequencer_if.sv
// Command, unit-launch and result-mux signals of the MDR sequencer bundled as one port.
// master = caller plus arithmetic units; slave = the sequencer itself.
interface mdr_sequencer_if #(
    parameter int NBits = 16
);
    logic             start;
    logic [1:0]       op;
    logic [NBits-1:0] data_x;
    logic [NBits-1:0] data_y;
    logic [NBits-1:0] operand_x;
    logic [NBits-1:0] operand_y;
    logic             mult_start;
    logic             div_start;
    logic             sqr_start;
    logic             mult_done;
    logic             div_done;
    logic             sqr_done;
    logic [NBits-1:0] mux_result;
    logic [1:0]       mux_selector;
    logic [NBits-1:0] result;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, op, data_x, data_y, mult_done, div_done, sqr_done, mux_result,
        input  operand_x, operand_y, mult_start, div_start, sqr_start,
               mux_selector, result, busy, done, error
    );

    modport slave (
        input  start, op, data_x, data_y, mult_done, div_done, sqr_done, mux_result,
        output operand_x, operand_y, mult_start, div_start, sqr_start,
               mux_selector, result, busy, done, error
    );
endinterface

// File: rtl/mdr_sequencer.sv
// MDR sequencer: launches one mult/div/sqrt unit per request, steers the result mux, captures the result.
// Latency start->done = unit time + 3 cycles; no backpressure, start is dropped while busy.
module mdr_sequencer #(
    parameter int NBits       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    mdr_sequencer_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [NBits-1:0] opx_q, opx_d;
    logic [NBits-1:0] opy_q, opy_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       mux_sel_q, mux_sel_d;
    logic [NBits-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             mult_start_q, mult_start_d;
    logic             div_start_q, div_start_d;
    logic             sqr_start_q, sqr_start_d;

    logic sel_done;
    logic timer_expired;
    logic accept;

    // Only the launched unit's completion may advance the FSM.
    always_comb begin
        case (op_q)
            2'b00:   sel_done = bus.mult_done;
            2'b01:   sel_done = bus.div_done;
            2'b10:   sel_done = bus.sqr_done;
            default: sel_done = 1'b0;
        endcase
    end

    assign timer_expired = (timer_q == TW'(TIMEOUT_CYC - 1));
    assign accept = bus.start && (bus.op != 2'b11) &&
                    !((bus.op == 2'b01) && (bus.data_y == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_LAUNCH;
            ST_LAUNCH:  state_d = ST_WAIT;
            ST_WAIT: begin
                // A completion seen on the timeout cycle still wins.
                if (sel_done)           state_d = ST_CAPTURE;
                else if (timer_expired) state_d = ST_IDLE;
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d         = op_q;
        opx_d        = opx_q;
        opy_d        = opy_q;
        timer_d      = timer_q;
        mux_sel_d    = mux_sel_q;
        result_d     = result_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        sqr_start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d         = bus.op;
                    opx_d        = bus.data_x;
                    opy_d        = bus.data_y;
                    mux_sel_d    = bus.op;
                    mult_start_d = (bus.op == 2'b00);
                    div_start_d  = (bus.op == 2'b01);
                    sqr_start_d  = (bus.op == 2'b10);
                end else if (bus.start) begin
                    // Rejected request: invalid op reports 0, divide-by-zero reports all ones.
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    result_d = (bus.op == 2'b11) ? '0 : '1;
                end
            end
            ST_LAUNCH: begin
                timer_d   = '0;
                mux_sel_d = op_q;
            end
            ST_WAIT: begin
                if (!sel_done) begin
                    if (timer_expired) begin
                        done_d   = 1'b1;
                        error_d  = 1'b1;
                        result_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                result_d = bus.mux_result;
                done_d   = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= 2'b00;
            opx_q        <= '0;
            opy_q        <= '0;
            timer_q      <= '0;
            mux_sel_q    <= 2'b00;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            sqr_start_q  <= 1'b0;
        end else begin
            op_q         <= op_d;
            opx_q        <= opx_d;
            opy_q        <= opy_d;
            timer_q      <= timer_d;
            mux_sel_q    <= mux_sel_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            sqr_start_q  <= sqr_start_d;
        end
    end

    assign bus.operand_x    = opx_q;
    assign bus.operand_y    = opy_q;
    assign bus.mux_selector = mux_sel_q;
    assign bus.result       = result_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.mult_start   = mult_start_q;
    assign bus.div_start    = div_start_q;
    assign bus.sqr_start    = sqr_start_q;
endmodule

// File: tb/tb_mdr_sequencer.sv
// Scoreboard bench for mdr_sequencer: randomized requests against an arithmetic reference model.
module tb_mdr_sequencer;
    localparam int NB = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    logic [NB-1:0] mult_res = '0, div_res = '0, sqr_res = '0;
    logic [1:0]    last_sel = 2'b00;

    typedef struct {
        logic [NB-1:0] res;
        logic          err;
        int            cyc;
        logic [1:0]    sel;
        int            launch;   // -1: no unit launched, else the op code launched
    } exp_t;
    exp_t sb[$];

    mdr_sequencer_if #(.NBits(NB)) bus();

    mdr_sequencer #(.NBits(NB), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mux_result = (bus.mux_selector == 2'b00) ? mult_res :
                            (bus.mux_selector == 2'b01) ? div_res  :
                            (bus.mux_selector == 2'b10) ? sqr_res  : '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [NB-1:0] ref_res(input logic [1:0] o, input logic [NB-1:0] x,
                                              input logic [NB-1:0] y);
        logic [31:0] p;
        case (o)
            2'b00:   begin p = x * y; return p[NB-1:0]; end
            2'b01:   return x / y;
            2'b10:   return NB'(isqrt(int'(x)));
            default: return '0;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.mult_done = 1'b0;
        bus.div_done  = 1'b0;
        bus.sqr_done  = 1'b0;
    endtask

    // Issue one request at the current falling edge; d = unit latency in cycles (0 = never completes).
    // noise: 0 quiet, 1 random foreign dones and starts, 2 foreign dones held high and start every cycle.
    task automatic run_op(input logic [1:0] o, input logic [NB-1:0] x, input logic [NB-1:0] y,
                          input int d, input int noise, input int gap);
        exp_t e;
        int   n, span;
        bit   launch, fires;
        logic nz;
        n      = cyc;
        launch = (o != 2'b11) && !((o == 2'b01) && (y == '0));
        fires  = launch && (d >= 1) && (d <= TO);
        e.launch = launch ? int'(o) : -1;
        if (!launch) begin
            e.res = (o == 2'b11) ? '0 : '1;
            e.err = 1'b1;
            span  = 1;
        end else begin
            last_sel = o;
            e.res = fires ? ref_res(o, x, y) : '0;
            e.err = !fires;
            span  = fires ? d + 3 : TO + 2;
        end
        e.sel = last_sel;
        e.cyc = n + span;
        sb.push_back(e);
        bus.start = 1'b1; bus.op = o; bus.data_x = x; bus.data_y = y;
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            clear_inputs();
            bus.op = 2'($urandom); bus.data_x = NB'($urandom); bus.data_y = NB'($urandom);
            check("busy", bus.busy, (launch && k < span) ? 1 : 0);
            if (k < span) begin
                if (fires && k == 1 + d) begin
                    case (o)
                        2'b00: begin mult_res = ref_res(o, bus.operand_x, bus.operand_y); bus.mult_done = 1'b1; end
                        2'b01: begin div_res  = ref_res(o, bus.operand_x, bus.operand_y); bus.div_done  = 1'b1; end
                        default: begin sqr_res = ref_res(o, bus.operand_x, bus.operand_y); bus.sqr_done = 1'b1; end
                    endcase
                end
                if (noise != 0 && launch) begin
                    nz = (noise == 2) || ($urandom % 5 == 0);
                    if (o != 2'b00) bus.mult_done = nz;
                    if (o != 2'b01) bus.div_done  = nz;
                    if (o != 2'b10) bus.sqr_done  = nz;
                end
                if (noise == 2 || (noise == 1 && $urandom % 5 == 0)) bus.start = 1'b1;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            clear_inputs();
            check("idle_busy", bus.busy, 0);
        end
    endtask

    // Monitor: pops one expectation per done pulse and audits launch pulses since the previous done.
    initial begin
        int   pulse_cnt = 0;
        int   pulse_kind = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pulse_cnt = 0; pulse_kind = -1;
            end else begin
                if (bus.mult_start) begin pulse_cnt++; pulse_kind = 0; end
                if (bus.div_start)  begin pulse_cnt++; pulse_kind = 1; end
                if (bus.sqr_start)  begin pulse_cnt++; pulse_kind = 2; end
                if (bus.done) begin
                    if (sb.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("result", bus.result, e.res);
                        check("error", bus.error, e.err);
                        check("done_cycle", cyc, e.cyc);
                        check("mux_selector", bus.mux_selector, e.sel);
                        check("launch_count", pulse_cnt, (e.launch >= 0) ? 1 : 0);
                        if (e.launch >= 0) check("launch_unit", pulse_kind, e.launch);
                    end
                    pulse_cnt = 0; pulse_kind = -1;
                end else if (bus.error) begin
                    check("error_without_done", 1, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_operand_x"}, bus.operand_x, 0);
        check({tag, "_operand_y"}, bus.operand_y, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_mux_selector"}, bus.mux_selector, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done_error"}, {bus.done, bus.error}, 0);
        check({tag, "_starts"}, {bus.mult_start, bus.div_start, bus.sqr_start}, 0);
    endtask

    initial begin
        logic [1:0]    o;
        logic [NB-1:0] x, y;
        int            d;
        reset = 1'b1;
        clear_inputs();
        bus.op = 2'b00; bus.data_x = '0; bus.data_y = '0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b00, 16'd7, 16'd9, 3, 0, 0);      // mult example
        run_op(2'b01, 16'd100, 16'd0, 0, 0, 0);    // divide by zero, issued as previous done pulses
        run_op(2'b10, 16'd144, 16'd0, 4, 2, 1);    // sqrt, foreign dones held high, start spam
        run_op(2'b11, 16'd5, 16'd5, 0, 0, 1);      // invalid op
        run_op(2'b00, 16'd3, 16'd4, 0, 0, 1);      // timeout
        run_op(2'b01, 16'd1000, 16'd7, TO, 1, 0);  // completion on the timeout cycle wins
        run_op(2'b10, 16'd99, 16'd0, 1, 0, 0);     // fastest completion
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 2, 1, 2);

        // Reset while waiting on the multiplier: outputs clear at once and no done follows.
        bus.start = 1'b1; bus.op = 2'b00; bus.data_x = 16'd5; bus.data_y = 16'd6;
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        last_sel = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_op(2'b01, 16'd500, 16'd20, 5, 1, 0);

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            x = NB'($urandom);
            y = NB'($urandom);
            if (o == 2'b01 && $urandom % 4 == 0) y = '0;
            d = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 12);
            run_op(o, x, y, d, 1, int'($urandom % 3));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
